// File: rtl/serial_tx_piso.sv
// -----------------------------------------------------------------------------
// serial_tx_piso
// Parallel-in / serial-out framed transmitter. A word accepted via the
// load_valid/load_ready handshake is sent on tx_out as one frame: a start bit
// (0), the data bits LSB first, then a stop bit (1). Each bit is held for
// BIT_CYCLES clocks. The line idles high.
//
// Ports
//   clk         in   1      single clock, posedge
//   rstn        in   1      asynchronous active-low reset
//   data_in     in   WIDTH  word to send, sampled only on an accepted handshake
//   load_valid  in   1      producer offers a word
//   load_ready  out  1      high while idle (decoded from state)
//   tx_out      out  1      registered serial line, 1 when idle
//   busy        out  1      registered, 1 while a frame is on the line
//   done        out  1      registered one-cycle pulse when a frame finishes
// -----------------------------------------------------------------------------
module serial_tx_piso #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             tx_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(BIT_CYCLES + 1);
  localparam int BW = $clog2(WIDTH + 1);

  localparam logic [CW-1:0] CYC_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CYC_ONE  = CW'(1);
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_ZERO = {BW{1'b0}};
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cyc_q,   cyc_d;
  logic [BW-1:0]    bit_q,   bit_d;
  logic             tx_q,    tx_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  logic             bit_end;
  logic [WIDTH-1:0] shift_next;

  // The current serial bit has been held for its full BIT_CYCLES clocks.
  assign bit_end    = (cyc_q == CYC_LAST);
  assign shift_next = shift_q >> 1'b1;

  // Next-state and next-output logic for the framing FSM.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Only an idle transmitter looks at load_valid, so an unknown
        // load_valid during a frame cannot disturb it.
        if (load_valid) begin
          shift_d = data_in;
          state_d = S_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          cyc_d   = CYC_ZERO;
        end else begin
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end

      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
          bit_d   = BIT_ZERO;
          cyc_d   = CYC_ZERO;
        end else begin
          cyc_d   = cyc_q + CYC_ONE;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          cyc_d = CYC_ZERO;
          if (bit_q == BIT_LAST) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            // Present the next LSB on the line as the register shifts.
            shift_d = shift_next;
            tx_d    = shift_next[0];
            bit_d   = bit_q + BIT_ONE;
          end
        end else begin
          cyc_d = cyc_q + CYC_ONE;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cyc_d   = CYC_ZERO;
        end else begin
          cyc_d   = cyc_q + CYC_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        cyc_d   = CYC_ZERO;
        bit_d   = BIT_ZERO;
      end
    endcase
  end

  // State and output registers; reset aborts any frame and releases the line high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      shift_q <= {WIDTH{1'b0}};
      cyc_q   <= CYC_ZERO;
      bit_q   <= BIT_ZERO;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign load_ready = (state_q == S_IDLE);
  assign tx_out     = tx_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_serial_tx_piso.sv
// -----------------------------------------------------------------------------
// tb_serial_tx_piso
// Drives two transmitters (BIT_CYCLES=1 and BIT_CYCLES=4, both 8 data bits)
// from the same stimulus and compares every output on every cycle against a
// frame-timeline reference model: after an accept at edge k, the line value
// at elapsed cycle e is bit (e / BIT_CYCLES) of the frame {stop, data, start}.
// -----------------------------------------------------------------------------
module tb_serial_tx_piso;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] data_in;
  logic       load_valid;

  logic rdy0, tx0, busy0, done0;
  logic rdy1, tx1, busy1, done1;

  always #5 clk = ~clk;

  serial_tx_piso #(.WIDTH(W), .BIT_CYCLES(1)) dut (
    .clk(clk), .rstn(rstn), .data_in(data_in), .load_valid(load_valid),
    .load_ready(rdy0), .tx_out(tx0), .busy(busy0), .done(done0)
  );

  serial_tx_piso #(.WIDTH(W), .BIT_CYCLES(4)) dut4 (
    .clk(clk), .rstn(rstn), .data_in(data_in), .load_valid(load_valid),
    .load_ready(rdy1), .tx_out(tx1), .busy(busy1), .done(done1)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, one entry per transmitter.
  bit         m_active [2];
  int         m_e      [2];
  logic [7:0] m_word   [2];
  bit         m_done   [2];
  int         m_bc     [2] = '{1, 4};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_tx(input int i);
    int idx;
    if (!m_active[i]) return 1'b1;
    idx = m_e[i] / m_bc[i];
    if (idx == 0) return 1'b0;
    if (idx <= W) return m_word[i][idx-1];
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 1'b0;
      m_e[i]      = 0;
      m_done[i]   = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (rstn !== 1'b1) return;
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0;
      if (m_active[i]) begin
        m_e[i]++;
        if (m_e[i] == (W + 2) * m_bc[i]) begin
          m_active[i] = 1'b0;
          m_done[i]   = 1'b1;
        end
      end else if (load_valid === 1'b1) begin
        m_active[i] = 1'b1;
        m_e[i]      = 0;
        m_word[i]   = data_in;
      end
    end
  endtask

  task automatic check_all();
    chk("tx_bc1",    {31'd0, tx0},   {31'd0, m_tx(0)});
    chk("busy_bc1",  {31'd0, busy0}, {31'd0, m_active[0]});
    chk("done_bc1",  {31'd0, done0}, {31'd0, m_done[0]});
    chk("ready_bc1", {31'd0, rdy0},  {31'd0, !m_active[0]});
    chk("tx_bc4",    {31'd0, tx1},   {31'd0, m_tx(1)});
    chk("busy_bc4",  {31'd0, busy1}, {31'd0, m_active[1]});
    chk("done_bc4",  {31'd0, done1}, {31'd0, m_done[1]});
    chk("ready_bc4", {31'd0, rdy1},  {31'd0, !m_active[1]});
  endtask

  task automatic cycle(input logic lv, input logic [7:0] d);
    load_valid = lv;
    data_in    = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100 && (m_active[0] || m_active[1]); n++)
      cycle(1'b0, 8'($urandom));
  endtask

  int cnt;
  int lat;
  bit found;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn       = 1'b0;
    load_valid = 1'b0;
    data_in    = 8'h00;
    model_reset();

    // Reset state held over two clocks.
    #8  check_all();
    #10 check_all();
    #2  rstn = 1'b1;
    cycle(1'b0, 8'h00);

    // Single frame 0xA5.
    cycle(1'b1, 8'hA5);
    wait_idle();

    // Back-to-back with load_valid held high: 0x3C then 0xC3.
    cnt = 0;
    cycle(1'b1, 8'h3C);
    cnt += int'(done0);
    for (int n = 0; n < 60; n++) begin
      cycle((n < 11) ? 1'b1 : 1'b0, 8'hC3);
      cnt += int'(done0);
    end
    chk("b2b_done_pulses", 32'(cnt), 32'd2);
    wait_idle();

    // load_valid pulse mid-frame must be ignored.
    cycle(1'b1, 8'h00);
    repeat (3) cycle(1'b0, 8'h5A);
    cycle(1'b1, 8'hFF);
    wait_idle();

    // Unknown load_valid/data while both transmitters are busy.
    cycle(1'b1, 8'h55);
    repeat (5) cycle(1'bx, 8'hxx);
    wait_idle();

    // Asynchronous reset in the middle of a frame.
    cycle(1'b1, 8'h96);
    repeat (4) cycle(1'b0, 8'h00);
    @(posedge clk);
    model_edge();
    #2 rstn = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    check_all();
    @(negedge clk);
    check_all();
    rstn = 1'b1;
    repeat (2) cycle(1'b0, 8'h00);
    cycle(1'b1, 8'h81);
    wait_idle();

    // Frame timing on the BIT_CYCLES=4 transmitter: done at edge k+40.
    cycle(1'b1, 8'h01);
    lat   = 0;
    found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      cycle(1'b0, 8'h00);
      lat++;
      if (done1 === 1'b1) found = 1'b1;
    end
    chk("bc4_done_edge", 32'(lat), 32'd40);
    wait_idle();

    // Randomized traffic.
    for (int n = 0; n < 600; n++)
      cycle(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0, 8'($urandom));
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
